// File: rtl/pulse_window_counter_pkg.sv
// Shared definitions for the time-correlation blocks:
// FSM encoding and default sizing of the pulse window counter.
`timescale 1ns/100ps
package pulse_window_counter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_WIN_W      = 16;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/pulse_window_counter_if.sv
// Valid/ready result stream between the result buffer
// and whoever consumes per-window counts.
`timescale 1ns/100ps
interface pulse_window_counter_if #(
    parameter int DW = 17
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pulse_window_counter_result_fifo.sv
// First-word-fall-through result buffer with sticky drop flag.
// Pointers carry one extra bit to tell full from empty.
`timescale 1ns/100ps
module result_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          overflow,
    pulse_window_counter_if.master rd
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, wr_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign rd.valid = !empty;
    assign rd.data  = mem_q[rd_q[AW-1:0]];
    assign overflow = ovf_q;

    // A full buffer still accepts when the head leaves this cycle.
    assign pop   = !empty && rd.ready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        ovf_d = ovf_q | (push && !wr_en);
        if (wr_en) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/pulse_window_counter.sv
// Gated photon counter: counts pulses over programmable windows
// and queues {count, sat} results for a valid/ready consumer.
`timescale 1ns/100ps
module pulse_window_counter
    import pulse_window_counter_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_W      = DEF_WIN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             overflow
);
    state_e             state_q, state_d;
    logic [WIN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic               sat_q, sat_d, sat_nxt;
    logic               push;

    pulse_window_counter_if #(.DW(CNT_W + 1)) res_if ();

    // Count including this cycle's pulse, clamped at all-ones.
    always_comb begin
        cnt_nxt = cnt_q;
        sat_nxt = sat_q;
        if (pulse) begin
            if (cnt_q == '1) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        push    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && window_len != '0) begin
                    state_d = ST_COUNT;
                    rem_d   = window_len;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rem_q == WIN_W'(1)) begin
                    push = 1'b1;
                    if (cont && window_len != '0) begin
                        rem_d = window_len;
                        cnt_d = '0;
                        sat_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = cnt_nxt;
                        sat_d   = sat_nxt;
                    end
                end else begin
                    rem_d = rem_q - 1'b1;
                    cnt_d = cnt_nxt;
                    sat_d = sat_nxt;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    result_fifo #(
        .DW    (CNT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({cnt_nxt, sat_nxt}),
        .overflow  (overflow),
        .rd        (res_if.master)
    );

    assign res_if.ready = out_ready;
    assign out_valid    = res_if.valid;
    assign out_count    = res_if.data[CNT_W:1];
    assign out_sat      = res_if.data[0];
    assign busy         = (state_q == ST_COUNT);
endmodule

// File: doc/pulse_window_counter.md
PULSE_WINDOW_COUNTER -- requirements
Module: pulse_window_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the width of the per-window photon count.
REQ-002 SHALL have parameter WIN_W, default 16, meaning the width of the window length in clk cycles.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of result-buffer entries; it SHALL be a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the 500 MHz system clock; it is the only clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pulse, input, 1 bit: single-cycle shaped photon event, synchronous to clk.
REQ-007 SHALL have port start, input, 1 bit: request to open a counting window.
REQ-008 SHALL have port abort, input, 1 bit: close the current window and discard its partial count.
REQ-009 SHALL have port cont, input, 1 bit: run back-to-back windows.
REQ-010 SHALL have port window_len, input, WIN_W bits: window length in cycles.
REQ-011 SHALL have port busy, output, 1 bit: high while state is COUNT.
REQ-012 SHALL have port out_valid, output, 1 bit: a result is available.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port out_count, output, CNT_W bits: the result count.
REQ-015 SHALL have port out_sat, output, 1 bit: the result count saturated.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, a result was dropped.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and COUNT.
REQ-018 In IDLE, when start=1 and window_len!=0, the block SHALL latch window_len into a remaining-cycle counter, clear the count, and enter COUNT on the next cycle.
REQ-019 In IDLE, start with window_len=0 SHALL be ignored; the block stays in IDLE.
REQ-020 A pulse SHALL be counted only in cycles where state=COUNT; a pulse coinciding with the start cycle is not counted.
REQ-021 The window SHALL last exactly the latched window_len cycles in COUNT.
REQ-022 The count SHALL saturate at 2^CNT_W-1 and set a per-window sat bit rather than wrap.
REQ-023 On the last COUNT cycle, the block SHALL push {count including that cycle's pulse, sat} into the FIFO.
REQ-024 At window end, if cont=1 and window_len!=0, the block SHALL reload window_len, clear count/sat, and remain in COUNT with no gap cycle; otherwise it SHALL go to IDLE.
REQ-025 start asserted while in COUNT SHALL be ignored.
REQ-026 abort=1 SHALL force IDLE on the next cycle with no push; abort overrides window end and cont in the same cycle.
REQ-027 The FIFO SHALL be first-word-fall-through: out_valid, out_count and out_sat reflect the head entry; a pop occurs when out_valid and out_ready are both 1.
REQ-028 A push into a full FIFO without a simultaneous pop SHALL drop the new result and set overflow; a push and a pop in the same cycle when full SHALL both succeed.
REQ-029 A push into an empty FIFO SHALL raise out_valid on the following cycle.
REQ-030 overflow SHALL stay set until reset.
REQ-031 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, using one extra bit to distinguish full from empty.

Reset
REQ-032 Assertion of rst_n=0 SHALL asynchronously force IDLE, busy=0, out_valid=0, out_count=0, out_sat=0 and overflow=0, empty the FIFO, and clear the count and remaining-cycle registers.
REQ-033 Reset asserted mid-window SHALL discard the partial window with no result produced.
REQ-034 Leaving reset SHALL be synchronous to clk; the first start is accepted on the first clk edge after rst_n=1.

Structure
REQ-035 The FSM state encoding and the default CNT_W, WIN_W and FIFO_DEPTH constants SHALL live in the shared package used by the time-correlation blocks.
REQ-036 The result buffer SHALL be a separate sub-module, result_fifo, with data width CNT_W+1.

Verification
REQ-037 Scenario: window_len=10, start, pulses in window cycles 1, 4 and 10 -> one result out_count=3, out_sat=0; busy high for exactly 10 cycles.
REQ-038 Scenario: CNT_W=4, window_len=20, pulse every cycle -> out_count=15, out_sat=1.
REQ-039 Scenario: cont=1, window_len=5, pulse held high -> consecutive results of 5 each, with busy never dropping between windows.
REQ-040 Scenario: out_ready=0, cont=1, window_len=3 for 5 windows -> 4 results buffered, overflow=1, and the head entry unchanged.
REQ-041 Scenario: abort in window cycle 3 of 8 -> no result, IDLE next cycle; a later start with window_len=2 and 2 pulses -> out_count=2.
REQ-042 Scenario: rst_n low in window cycle 4 -> all outputs 0 immediately and no result after rst_n rises; start with window_len=0 -> busy stays 0.
